// File: rtl/ab_stim_gen_pkg.sv
// Shared types and constants for the A/B stimulus/response engine.
package ab_stim_pkg;

    // Controller states; encoding is fixed so the state can be probed on-board.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit positions inside a pattern word {A, B, Y_expected}.
    localparam int PAT_A = 2;
    localparam int PAT_B = 1;
    localparam int PAT_Y = 0;

endpackage

// File: rtl/ab_stim_gen_if.sv
// Bus between the stimulus engine and whoever loads patterns and reads results.
interface ab_stim_gen_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic             pat_we;
    logic [AW-1:0]    pat_addr;
    logic [2:0]       pat_wdata;
    logic             y_in;
    logic             a_out;
    logic             b_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [AW-1:0]    first_err_idx;

    // Controller/test side: loads patterns, starts runs, feeds back Y.
    modport master (
        output start, pat_we, pat_addr, pat_wdata, y_in,
        input  a_out, b_out, busy, done, pass, err_cnt, first_err_idx
    );

    // Engine side.
    modport slave (
        input  start, pat_we, pat_addr, pat_wdata, y_in,
        output a_out, b_out, busy, done, pass, err_cnt, first_err_idx
    );
endinterface

// File: rtl/ab_stim_gen_delay_line.sv
// LAT-stage shift register carrying {valid, expected} from stimulus to compare.
module ab_delay_line #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_exp,
    output logic out_valid,
    output logic out_exp
);
    logic [LAT-1:0] valid_q;
    logic [LAT-1:0] exp_q;

    // Shift one stage per clock; stage 0 takes the vector just presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            exp_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            exp_q[0]   <= in_exp;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                exp_q[i]   <= exp_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_exp   = exp_q[LAT-1];
endmodule

// File: rtl/ab_stim_gen.sv
// Stimulus/response engine: plays A/B vectors from a pattern table into an FSM
// under test and compares its Y output LAT cycles later.
module ab_stim_gen #(
    parameter int DEPTH = 8,
    parameter int LAT   = 1,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    ab_stim_gen_if.slave bus
);
    import ab_stim_pkg::*;

    localparam int            AW       = $clog2(DEPTH);
    localparam int            IW       = AW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] END_IDX  = IW'(DEPTH);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;      // next vector to present
    logic [IW-1:0]    cmp_q, cmp_d;      // index of the vector being compared
    logic             a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [AW-1:0]    first_q, first_d;
    logic             pass_q, pass_d;
    logic [2:0]       table_q [DEPTH];

    logic       accept;
    logic       push_valid, push_exp;
    logic       dl_valid, dl_exp;
    logic       last_cmp;
    logic [2:0] cur_word;

    assign accept = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Pattern table: writable only while no run is in progress.
    // NOTE: the table is tiny and must read as zero after any reset, so it is
    // built from resettable flops rather than an inferred RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (accept && bus.pat_we && ({1'b0, bus.pat_addr} < END_IDX)) begin
            table_q[bus.pat_addr] <= bus.pat_wdata;
        end
    end

    ab_delay_line #(.LAT(LAT)) u_delay (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (push_valid),
        .in_exp    (push_exp),
        .out_valid (dl_valid),
        .out_exp   (dl_exp)
    );

    // Next-state logic: compare stage first, then sequencing per state.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmp_d      = cmp_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        first_d    = first_q;
        pass_d     = pass_q;
        push_valid = 1'b0;
        push_exp   = 1'b0;
        cur_word   = table_q[idx_q[AW-1:0]];
        last_cmp   = dl_valid && (cmp_q == LAST_IDX);

        if (dl_valid) begin
            cmp_d = cmp_q + 1'b1;
            if (bus.y_in != dl_exp) begin
                if (err_q == '0) first_d = cmp_q[AW-1:0];
                if (err_q != '1) err_d = err_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_RUN;
                    idx_d      = IW'(1);
                    cmp_d      = '0;
                    err_d      = '0;
                    first_d    = '0;
                    pass_d     = 1'b0;
                    a_d        = table_q[0][PAT_A];
                    b_d        = table_q[0][PAT_B];
                    push_valid = 1'b1;
                    push_exp   = table_q[0][PAT_Y];
                end
            end
            ST_RUN: begin
                if (idx_q == END_IDX) begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = last_cmp ? ST_DONE : ST_DRAIN;
                end else begin
                    a_d        = cur_word[PAT_A];
                    b_d        = cur_word[PAT_B];
                    push_valid = 1'b1;
                    push_exp   = cur_word[PAT_Y];
                    idx_d      = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (last_cmp) state_d = ST_DONE;
            end
        endcase

        // The verdict includes a mismatch found on the very last compare.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) pass_d = (err_d == '0);
    end

    // State and result registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cmp_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmp_q   <= cmp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.a_out         = a_q;
    assign bus.b_out         = b_q;
    assign bus.busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done          = (state_q == ST_DONE);
    assign bus.pass          = pass_q;
    assign bus.err_cnt       = err_q;
    assign bus.first_err_idx = first_q;
endmodule

// File: tb/tb_ab_stim_gen.sv
// Bench for ab_stim_gen: two instances (DEPTH=4/LAT=1/CNT_W=4 and
// DEPTH=8/LAT=3/CNT_W=2) driven through one set of bench signals, with the
// expected verdict computed directly from the table and the Y sequence.
module tb_ab_stim_gen;

    typedef enum int {Y_FOLLOW, Y_SCHED, Y_STUCK} ymode_e;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       start;
    logic       pat_we;
    logic [3:0] pat_addr;
    logic [2:0] pat_wdata;
    logic       y_drv;
    ymode_e     ymode;

    int depth;
    int lat;
    int cmax;
    int n_chk = 0;
    int n_err = 0;

    logic [2:0] tbl [16];
    logic       ys  [16];

    always #5 clk = ~clk;

    ab_stim_gen_if #(.DEPTH(4), .CNT_W(4)) bus_a ();
    ab_stim_gen_if #(.DEPTH(8), .CNT_W(2)) bus_b ();

    assign bus_a.start     = start & ~sel;
    assign bus_b.start     = start & sel;
    assign bus_a.pat_we    = pat_we & ~sel;
    assign bus_b.pat_we    = pat_we & sel;
    assign bus_a.pat_addr  = pat_addr[1:0];
    assign bus_b.pat_addr  = pat_addr[2:0];
    assign bus_a.pat_wdata = pat_wdata;
    assign bus_b.pat_wdata = pat_wdata;
    // FSM-under-test model for instance A: Y = A & B of the registered stimulus.
    assign bus_a.y_in      = (ymode == Y_FOLLOW) ? (bus_a.a_out & bus_a.b_out) : y_drv;
    assign bus_b.y_in      = y_drv;

    ab_stim_gen #(.DEPTH(4), .LAT(1), .CNT_W(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    ab_stim_gen #(.DEPTH(8), .LAT(3), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [1:0] o_ab;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_err;
    logic [2:0] o_first;

    assign o_ab    = sel ? {bus_b.a_out, bus_b.b_out} : {bus_a.a_out, bus_a.b_out};
    assign o_busy  = sel ? bus_b.busy : bus_a.busy;
    assign o_done  = sel ? bus_b.done : bus_a.done;
    assign o_pass  = sel ? bus_b.pass : bus_a.pass;
    assign o_err   = sel ? {2'b00, bus_b.err_cnt} : bus_a.err_cnt;
    assign o_first = sel ? bus_b.first_err_idx : {1'b0, bus_a.first_err_idx};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic select(input logic s);
        sel   = s;
        depth = s ? 8 : 4;
        lat   = s ? 3 : 1;
        cmax  = s ? 3 : 15;
        #1;
    endtask

    task automatic load();
        for (int i = 0; i < depth; i++) begin
            pat_we    = 1'b1;
            pat_addr  = 4'(i);
            pat_wdata = tbl[i];
            tick();
        end
        pat_we = 1'b0;
    endtask

    // Y presented at the edge that compares vector k (junk outside the window).
    task automatic set_y(input int k);
        case (ymode)
            Y_STUCK: y_drv = 1'b1;
            Y_SCHED: y_drv = (k >= 0 && k < depth) ? ys[k] : 1'($urandom);
            default: y_drv = 1'($urandom);
        endcase
    endtask

    // One run: checks the stimulus each cycle and the final verdict.
    // poke_at: pulse start/pat_we so they land on that edge.
    // abort_at: assert reset right after that edge and stop the run.
    task automatic run(input string tag, input int poke_at, input int abort_at);
        int   mism;
        int   exp_first;
        int   exp_err;
        int   last;
        logic found;
        mism      = 0;
        exp_first = 0;
        found     = 1'b0;
        for (int k = 0; k < depth; k++) begin
            if (ymode == Y_FOLLOW) ys[k] = tbl[k][2] & tbl[k][1];
            if (ymode == Y_STUCK) ys[k] = 1'b1;
            if (ys[k] != tbl[k][0]) begin
                if (!found) exp_first = k;
                found = 1'b1;
                mism++;
            end
        end
        exp_err = (mism > cmax) ? cmax : mism;
        last    = depth - 1 + lat;

        start = 1'b1;
        set_y(-lat);
        tick();
        start = 1'b0;
        for (int j = 0; j <= last; j++) begin
            if (j < depth) check($sformatf("%s_ab%0d", tag, j), 32'(o_ab), 32'(tbl[j][2:1]));
            else check($sformatf("%s_ab%0d", tag, j), 32'(o_ab), 0);
            if (j < last) check($sformatf("%s_busy%0d", tag, j), {30'd0, o_busy, o_done}, 2);
            if (j == abort_at) begin
                reset = 1'b0;
                #1;
                check({tag, "_abort"}, {28'd0, o_ab, o_busy, o_done}, 0);
                #1;
                reset = 1'b1;
                return;
            end
            if (j == last) break;
            set_y(j + 1 - lat);
            if (j + 1 == poke_at) begin
                start     = 1'b1;
                pat_we    = 1'b1;
                pat_addr  = 4'd0;
                pat_wdata = ~tbl[0];
            end
            tick();
            start  = 1'b0;
            pat_we = 1'b0;
        end
        check({tag, "_done"}, {30'd0, o_busy, o_done}, 1);
        check({tag, "_err"}, 32'(o_err), 32'(exp_err));
        check({tag, "_first"}, 32'(o_first), 32'(exp_first));
        check({tag, "_pass"}, 32'(o_pass), 32'(mism == 0));
        set_y(-1);
        tick();
        check({tag, "_hold"}, {o_done, o_pass, o_err, 1'b0, o_first},
              {1'b1, 1'(mism == 0), 4'(exp_err), 1'b0, 3'(exp_first)});
    endtask

    task automatic set_base_table();
        tbl[0] = 3'b000;
        tbl[1] = 3'b100;
        tbl[2] = 3'b010;
        tbl[3] = 3'b111;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ymode = Y_SCHED;
        select(1'b0);
        repeat (2) begin
            start     = 1'($urandom);
            pat_we    = 1'($urandom);
            pat_addr  = 4'($urandom);
            pat_wdata = 3'($urandom);
            y_drv     = 1'($urandom);
            sel       = 1'($urandom);
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            select(1'(s));
            check($sformatf("rst%0d_ab", s), 32'(o_ab), 0);
            check($sformatf("rst%0d_flags", s), {29'd0, o_busy, o_done, o_pass}, 0);
            check($sformatf("rst%0d_err", s), 32'(o_err), 0);
            check($sformatf("rst%0d_first", s), 32'(o_first), 0);
        end
        start  = 1'b0;
        pat_we = 1'b0;
        select(1'b0);
        reset = 1'b1;
        tick();

        // Instance A: directed runs with the A&B model as FSM under test.
        ymode = Y_FOLLOW;
        set_base_table();
        load();
        run("pass", -1, -1);

        tbl[2] = 3'b011;
        load();
        run("single", -1, -1);

        ymode = Y_STUCK;
        set_base_table();
        load();
        run("stuck", -1, -1);

        ymode = Y_FOLLOW;
        run("poke", 2, -1);
        run("rerun", -1, -1);

        run("abort", -1, 2);
        tick();
        for (int i = 0; i < 16; i++) tbl[i] = 3'b000;
        run("cleared", -1, -1);
        set_base_table();
        load();
        run("reload", -1, -1);

        // Instance A: random tables and Y sequences.
        ymode = Y_SCHED;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < depth; i++) begin
                tbl[i] = 3'($urandom);
                ys[i]  = 1'($urandom);
            end
            load();
            run($sformatf("rnda%0d", r), -1, -1);
        end

        // Instance B: saturation, then random runs through the drain phase.
        select(1'b1);
        ymode = Y_STUCK;
        for (int i = 0; i < depth; i++) tbl[i] = {2'($urandom), 1'b0};
        load();
        run("sat", -1, -1);

        ymode = Y_SCHED;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < depth; i++) begin
                tbl[i] = 3'($urandom);
                ys[i]  = (r == 0) ? tbl[i][0] : 1'($urandom);
            end
            load();
            run($sformatf("rndb%0d", r), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
